rule_scheduler: RTL and testbench

Drives the `network_logic` update block by issuing one rule index per step and registering `next_state` back as `current_state`. Each round executes every rule exactly once, either in a fresh random permutation (Fisher–Yates shuffle drawn from an LFSR) or in fixed index order. It runs a programmable number of rounds and pulses a snapshot strobe at each round end for the trace/readout logic.

---
 rtl/gsro_pkg.sv | 41 ++++
 rtl/rule_lfsr.sv | 34 +++
 rtl/rule_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_rule_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsro_pkg.sv
// gsro_pkg: shared constants, types and helpers for the rule scheduler.
//   RULES / NUM_RULES / LOG_RULES  - state width, rule count, rule index width
//   LFSR_POLY / LFSR_DEFAULT_SEED  - Galois LFSR tap mask and seed used for 0 / reset
//   SLOW_RULE_MASK                 - rules whose logic result is registered (2-cycle hold)
//   sched_state_t                  - scheduler FSM encoding
package gsro_pkg;

  localparam int RULES     = 61;
  localparam int NUM_RULES = 38;
  localparam int LOG_RULES = 6;

  localparam logic [15:0] LFSR_POLY         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  localparam logic [NUM_RULES-1:0] SLOW_RULE_MASK = (38'd1 << 17) | (38'd1 << 18);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SHUFFLE   = 3'd2,
    EXEC      = 3'd3,
    ROUND_END = 3'd4,
    FINISH    = 3'd5
  } sched_state_t;

  // Smallest 2^k-1 that is >= i: smear the highest set bit downwards.
  function automatic logic [LOG_RULES-1:0] fy_mask(input logic [LOG_RULES-1:0] i);
    logic [LOG_RULES-1:0] m;
    m = i;
    for (int s = 1; s < LOG_RULES; s++) begin
      m = m | (i >> s);
    end
    return m;
  endfunction

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/rule_lfsr.sv
// rule_lfsr: 16-bit Galois LFSR supplying shuffle candidates.
//   clk, reset - clock, synchronous active-high reset (value -> default seed)
//   load, seed - load seed (a zero seed is replaced by the default seed)
//   advance    - step the LFSR once; otherwise it holds
//   value      - current LFSR contents
module rule_lfsr
  import gsro_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] lfsr_r;

  // LFSR register: reset, load, step or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      lfsr_r <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end else if (advance) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign value = lfsr_r;

endmodule

// File: rtl/rule_scheduler.sv
// rule_scheduler: issues one rule index per step to the network logic and
// registers its next_state back as current_state. Each round runs every rule
// once, either in a freshly Fisher-Yates-shuffled order or in index order.
//   clk, reset                 - clock, synchronous active-high reset
//   start                      - begin a run (only honoured when idle)
//   fixed_order, seed,
//   num_rounds, init_state     - run configuration, captured at start
//   next_state                 - network logic result for the presented rule
//   rule, current_state        - rule index and state fed to the network logic
//   busy, round_done, done,
//   round_count                - run status and round-end strobe
module rule_scheduler
  import gsro_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 fixed_order,
  input  logic [15:0]          seed,
  input  logic [15:0]          num_rounds,
  input  logic [RULES-1:0]     init_state,
  input  logic [RULES-1:0]     next_state,
  output logic [LOG_RULES-1:0] rule,
  output logic [RULES-1:0]     current_state,
  output logic                 busy,
  output logic                 round_done,
  output logic [15:0]          round_count,
  output logic                 done
);

  sched_state_t state_r, state_s;

  logic                 fixed_r;
  logic [15:0]          rounds_r;
  logic [15:0]          round_count_r;
  logic [RULES-1:0]     current_state_r;
  logic [LOG_RULES-1:0] table_r [NUM_RULES];
  logic [LOG_RULES-1:0] i_r;
  logic [LOG_RULES-1:0] k_r;
  logic                 slow_phase_r;
  logic [LOG_RULES-1:0] rule_hold_r;

  logic [15:0]          lfsr_val_s;
  logic                 start_s;
  logic [LOG_RULES-1:0] cand_s;
  logic                 accept_s;
  logic [LOG_RULES-1:0] exec_rule_s;
  logic                 latch_s;
  logic                 last_s;
  logic [15:0]          rc_inc_s;

  assign start_s  = (state_r == IDLE) && start;
  // Full-width AND keeps the candidate well-defined; the mask clears bits above i.
  assign cand_s   = LOG_RULES'(lfsr_val_s & 16'(fy_mask(i_r)));
  assign accept_s = (cand_s <= i_r);
  // Fixed-order rounds ignore the (possibly shuffled) table.
  assign exec_rule_s = fixed_r ? k_r : table_r[k_r];
  // A slow rule latches only in its second cycle.
  assign latch_s  = (state_r == EXEC) && (!SLOW_RULE_MASK[exec_rule_s] || slow_phase_r);
  assign last_s   = (k_r == LOG_RULES'(NUM_RULES - 1));
  assign rc_inc_s = round_count_r + 16'd1;

  rule_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (start_s),
    .seed    (seed),
    .advance (state_r == SHUFFLE),
    .value   (lfsr_val_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:      state_s = start_s ? LOAD : IDLE;
      LOAD: begin
        if (rounds_r == 16'd0) begin
          state_s = FINISH;
        end else begin
          state_s = fixed_r ? EXEC : SHUFFLE;
        end
      end
      SHUFFLE:   state_s = (accept_s && (i_r == LOG_RULES'(1))) ? EXEC : SHUFFLE;
      EXEC:      state_s = (latch_s && last_s) ? ROUND_END : EXEC;
      ROUND_END: begin
        if (rc_inc_s == rounds_r) begin
          state_s = FINISH;
        end else begin
          state_s = fixed_r ? EXEC : SHUFFLE;
        end
      end
      FINISH:    state_s = IDLE;
      default:   state_s = IDLE;
    endcase
  end

  // Run configuration, state vector, counters and round position.
  always_ff @(posedge clk) begin
    if (reset) begin
      fixed_r         <= 1'b0;
      rounds_r        <= 16'd0;
      round_count_r   <= 16'd0;
      current_state_r <= {RULES{1'b0}};
      i_r             <= LOG_RULES'(NUM_RULES - 1);
      k_r             <= {LOG_RULES{1'b0}};
      slow_phase_r    <= 1'b0;
      rule_hold_r     <= {LOG_RULES{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            fixed_r         <= fixed_order;
            rounds_r        <= num_rounds;
            round_count_r   <= 16'd0;
            current_state_r <= init_state;
          end
        end
        LOAD: begin
          i_r          <= LOG_RULES'(NUM_RULES - 1);
          k_r          <= {LOG_RULES{1'b0}};
          slow_phase_r <= 1'b0;
        end
        SHUFFLE: begin
          if (accept_s) begin
            i_r <= i_r - LOG_RULES'(1);
          end
        end
        EXEC: begin
          rule_hold_r <= exec_rule_s;
          if (latch_s) begin
            current_state_r <= next_state;
            slow_phase_r    <= 1'b0;
            k_r             <= last_s ? {LOG_RULES{1'b0}} : (k_r + LOG_RULES'(1));
          end else begin
            slow_phase_r <= 1'b1;
          end
        end
        ROUND_END: begin
          round_count_r <= rc_inc_s;
          i_r           <= LOG_RULES'(NUM_RULES - 1);
        end
        FINISH: begin
          rounds_r <= rounds_r;
        end
        default: begin
          rounds_r <= rounds_r;
        end
      endcase
    end
  end

  // Order table: identity on reset, one accepted swap per shuffle step.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_RULES; j++) begin
        table_r[j] <= LOG_RULES'(j);
      end
    end else if ((state_r == SHUFFLE) && accept_s) begin
      table_r[i_r]    <= table_r[cand_s];
      table_r[cand_s] <= table_r[i_r];
    end
  end

  // FSM outputs; rule holds its last issued value outside EXEC.
  always_comb begin
    busy       = 1'b0;
    round_done = 1'b0;
    done       = 1'b0;
    rule       = rule_hold_r;
    case (state_r)
      LOAD, SHUFFLE: busy = 1'b1;
      EXEC: begin
        busy = 1'b1;
        rule = exec_rule_s;
      end
      ROUND_END: begin
        busy       = 1'b1;
        round_done = 1'b1;
      end
      FINISH:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign current_state = current_state_r;
  assign round_count   = round_count_r;

endmodule

// File: tb/tb_rule_scheduler.sv
module tb_rule_scheduler;
  import gsro_pkg::*;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic                 fixed_order;
  logic [15:0]          seed;
  logic [15:0]          num_rounds;
  logic [RULES-1:0]     init_state;
  logic [RULES-1:0]     next_state;
  logic [LOG_RULES-1:0] rule;
  logic [RULES-1:0]     current_state;
  logic                 busy;
  logic                 round_done;
  logic [15:0]          round_count;
  logic                 done;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of expected latched rules, and log of observed ones.
  int sb_q [$];
  int obs_q [$];
  int obs_a [$];
  int lat_cnt = 0;

  // Reference shuffle model state.
  int          mtab [NUM_RULES];
  logic [15:0] mlfsr;

  rule_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .fixed_order   (fixed_order),
    .seed          (seed),
    .num_rounds    (num_rounds),
    .init_state    (init_state),
    .next_state    (next_state),
    .rule          (rule),
    .current_state (current_state),
    .busy          (busy),
    .round_done    (round_done),
    .round_count   (round_count),
    .done          (done)
  );

  // Network logic model: rotate left and toggle the bit of the rule.
  assign next_state = {current_state[RULES-2:0], current_state[RULES-1]} ^ (RULES'(1) << rule);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < NUM_RULES; j++) mtab[j] = j;
  endtask

  task automatic model_step();
    mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
  endtask

  task automatic model_shuffle();
    int i, m, c, t;
    i = NUM_RULES - 1;
    while (i > 0) begin
      m = 1;
      while (m < i) m = 2 * m + 1;
      c = int'(mlfsr) & m;
      model_step();
      if (c <= i) begin
        t = mtab[i]; mtab[i] = mtab[c]; mtab[c] = t;
        i--;
      end
    end
  endtask

  task automatic model_run(input bit fx, input logic [15:0] sd, input int nr);
    mlfsr = (sd == 16'h0000) ? 16'hACE1 : sd;
    for (int r = 0; r < nr; r++) begin
      if (!fx) model_shuffle();
      for (int k = 0; k < NUM_RULES; k++) sb_q.push_back(fx ? k : mtab[k]);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    sb_q.delete();
    obs_q.delete();
  endtask

  // Monitor: a change of current_state (not from load/reset) is one latched rule.
  logic [RULES-1:0]     prev_cs, prev_ns;
  logic [LOG_RULES-1:0] prev_rule, prev2_rule;
  bit                   prev_valid = 1'b0;
  bit                   prev_load  = 1'b0;
  logic [NUM_RULES-1:0] seen;
  always @(negedge clk) begin
    int exp_r;
    if (reset) begin
      prev_valid = 1'b0;
      seen       = '0;
      lat_cnt    = 0;
    end else begin
      if (prev_valid && !prev_load && (current_state !== prev_cs)) begin
        chk("latched_state", current_state, prev_ns);
        obs_q.push_back(int'(prev_rule));
        if (sb_q.size() == 0) begin
          chk("scoreboard_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          exp_r = sb_q.pop_front();
          chk("rule_order", prev_rule, exp_r);
        end
        if (SLOW_RULE_MASK[prev_rule]) chk("slow_rule_held_2cyc", prev2_rule, prev_rule);
        seen[prev_rule] = 1'b1;
        lat_cnt++;
      end
      if (round_done) begin
        chk("round_permutation_complete", seen, {NUM_RULES{1'b1}});
        seen    = '0;
        lat_cnt = 0;
      end
      prev2_rule = prev_rule;
      prev_rule  = rule;
      prev_cs    = current_state;
      prev_ns    = next_state;
      prev_load  = start && !busy;
      prev_valid = 1'b1;
    end
  end

  task automatic run(input bit fx, input logic [15:0] sd, input logic [15:0] nr,
                     input logic [RULES-1:0] init, input int extra_n, input bit do_abort,
                     output int rd_cnt, output int first_rd, output int done_n, output bit aborted);
    bit saw;
    rd_cnt = 0; first_rd = 0; done_n = 0; aborted = 1'b0; saw = 1'b0;
    @(posedge clk); #2;
    fixed_order = fx; seed = sd; num_rounds = nr; init_state = init; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (round_done) begin
        rd_cnt++;
        if (first_rd == 0) first_rd = n;
      end
      if (done) begin
        done_n = n;
        break;
      end
      if (do_abort && (rd_cnt == 1) && (lat_cnt >= 5)) begin
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_current_state", current_state, 64'd0);
        chk("abort_round_count", round_count, 16'd0);
        chk("abort_rule", rule, 6'd0);
        repeat (6) begin
          if (done) saw = 1'b1;
          @(negedge clk);
        end
        chk("abort_no_done", saw, 1'b0);
        aborted = 1'b1;
        break;
      end
      @(posedge clk); #2;
      start = (n == extra_n);
    end
    start = 1'b0;
    if (!aborted) chk("run_done_in_budget", (done_n != 0), 1'b1);
  endtask

  initial begin
    int rd, frd, dn;
    bit ab;
    reset = 1'b1; start = 1'b0; fixed_order = 1'b0; seed = 16'h0000;
    num_rounds = 16'd0; init_state = '0;
    model_reset();

    // Reset state.
    do_reset();
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rule", rule, 6'd0);
    chk("reset_current_state", current_state, 64'd0);
    chk("reset_round_count", round_count, 16'd0);
    chk("reset_done", done, 1'b0);
    chk("reset_round_done", round_done, 1'b0);

    // Fixed order, one round: 38 rules + 2 slow extra cycles.
    model_run(1'b1, 16'h0000, 1);
    run(1'b1, 16'h0000, 16'd1, '0, 0, 1'b0, rd, frd, dn, ab);
    chk("fixed_round_done_cycle", frd, 42);
    chk("fixed_done_cycle", dn, 43);
    chk("fixed_round_done_count", rd, 1);
    chk("fixed_round_count", round_count, 16'd1);
    chk("fixed_busy_at_done", busy, 1'b0);
    chk("fixed_sb_empty", sb_q.size(), 0);

    // Zero rounds: done two cycles after start, state = init.
    run(1'b0, 16'h1111, 16'd0, 61'h0ABC_DEF0_1234_5678, 0, 1'b0, rd, frd, dn, ab);
    chk("zero_done_cycle", dn, 2);
    chk("zero_no_round_done", rd, 0);
    chk("zero_current_state", current_state, 64'h0ABC_DEF0_1234_5678);
    chk("zero_round_count", round_count, 16'd0);

    // Random order, seed 1, three rounds.
    model_run(1'b0, 16'h0001, 3);
    run(1'b0, 16'h0001, 16'd3, 61'h1F00_0000_0000_00A5, 0, 1'b0, rd, frd, dn, ab);
    chk("rand_round_done_count", rd, 3);
    chk("rand_round_count", round_count, 16'd3);
    chk("rand_sb_empty", sb_q.size(), 0);

    // Start pulsed while busy is ignored; table left shuffled but order fixed.
    model_run(1'b1, 16'h0000, 2);
    run(1'b1, 16'h0000, 16'd2, 61'h5, 10, 1'b0, rd, frd, dn, ab);
    chk("restart_done_cycle", dn, 84);
    chk("restart_round_done_count", rd, 2);
    chk("restart_round_count", round_count, 16'd2);
    chk("restart_sb_empty", sb_q.size(), 0);

    // Seed 0 must behave like the default seed.
    do_reset();
    model_run(1'b0, 16'h0000, 1);
    run(1'b0, 16'h0000, 16'd1, 61'h3, 0, 1'b0, rd, frd, dn, ab);
    chk("seed0_sb_empty", sb_q.size(), 0);
    obs_a = obs_q;
    do_reset();
    model_run(1'b0, 16'hACE1, 1);
    run(1'b0, 16'hACE1, 16'd1, 61'h3, 0, 1'b0, rd, frd, dn, ab);
    chk("seedace1_len", obs_q.size(), NUM_RULES);
    chk("seed0_matches_ace1", (obs_q == obs_a), 1'b1);

    // Reset in round 2 EXEC, then a fresh run from an identity table.
    model_run(1'b0, 16'h1234, 3);
    run(1'b0, 16'h1234, 16'd3, 61'h7, 0, 1'b1, rd, frd, dn, ab);
    chk("abort_taken", ab, 1'b1);
    model_reset();
    sb_q.delete();
    model_run(1'b0, 16'hBEEF, 2);
    run(1'b0, 16'hBEEF, 16'd2, 61'h9, 0, 1'b0, rd, frd, dn, ab);
    chk("post_reset_round_done_count", rd, 2);
    chk("post_reset_round_count", round_count, 16'd2);
    chk("post_reset_sb_empty", sb_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
